// File: rtl/arb8_seg_ctrl.sv
// Eight-requester grant controller with one-hot/index/7-segment grant reporting.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (highest index wins).
module arb8_seg_ctrl #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout,
  output logic [6:0] HEX0
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cand;

  // Scan offsets from farthest to nearest so the first set bit at/after the pointer wins.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(7 - k);
      if (req[cand]) win = cand;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (req[i]) win = 3'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable && (|req)) begin
          state_d = S_GRANT;
          grant_d = 8'b1 << win;
          idx_d   = win;
          valid_d = 1'b1;
          cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = win + 3'd1;
`endif
        end
      end
      S_GRANT: begin
        // Release wins over a coinciding hold limit, so no timeout pulse in that case.
        if (!enable || !req[idx_q] || (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          to_d    = enable && req[idx_q];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Segment order g..a, active low.
  always_comb begin
    HEX0 = 7'b1111111;
    if (valid_q) begin
      unique case (idx_q)
        3'd0: HEX0 = 7'b1000000;
        3'd1: HEX0 = 7'b1111001;
        3'd2: HEX0 = 7'b0100100;
        3'd3: HEX0 = 7'b0110000;
        3'd4: HEX0 = 7'b0011001;
        3'd5: HEX0 = 7'b0010010;
        3'd6: HEX0 = 7'b0000010;
        3'd7: HEX0 = 7'b1111000;
        default: HEX0 = 7'b1111111;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = to_q;

endmodule

// File: doc/arb8_seg_ctrl.md
# arb8_seg_ctrl

Eight-requester grant controller for the shared 8-bit input channel that feeds the priority encoder/7-segment path on the board. Requesters (switch-driven or internal) raise `req` bits; the block grants one at a time, holds the grant until release or timeout, and reports the grantee as a one-hot vector, a 3-bit index, and a HEX0 digit. Arbitration policy is fixed-priority or round-robin, chosen at compile time.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held (≥2).
- `CNT_W`, default 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `enable`  input  1  arbitration enable (SW8 on board).
- `req`  input  8  request lines, bit i = requester i (SW7–SW0).
- `grant`  output  8  one-hot grant, registered.
- `grant_idx`  output  3  index of current grantee, registered.
- `grant_valid`  output  1  high while any grant is active (LED4).
- `timeout`  output  1  one-cycle pulse when a grant is forcibly revoked.
- `HEX0`  output  7  active-low 7-segment digit of `grant_idx`, bit0 = segment a.

## Operation
- States: IDLE, GRANT.
- IDLE: if `enable` && |`req`, select winner W, load `grant`=1<<W, `grant_idx`=W, `grant_valid`=1, clear hold counter, go GRANT. Otherwise stay; outputs inactive.
- GRANT, each cycle, priority order:
  1. `enable`=0 → revoke, go IDLE (no `timeout`).
  2. `req[grant_idx]`=0 → release, go IDLE.
  3. hold counter = MAX_HOLD−1 → revoke, pulse `timeout`, go IDLE.
  4. else counter += 1, stay.
- Revoke/release: `grant`=0, `grant_idx`=0, `grant_valid`=0 on the next edge.
- Requests from other indices during GRANT are ignored (no preemption).
- HEX0 decode of `grant_idx` when `grant_valid`=1: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000. When `grant_valid`=0: 1111111 (blank). HEX0 is driven from registered state only.
- Hold counter saturates logic-wise at MAX_HOLD−1; never wraps.

## Timing
- Reset (async, immediate): state=IDLE, `grant`=0, `grant_idx`=0, `grant_valid`=0, `timeout`=0, HEX0=1111111, RR pointer=0, counter=0. Reset mid-grant drops the grant in the same instant.
- Request-to-grant latency: 1 cycle (req sampled at edge N, grant visible after edge N).
- Release-to-revoke latency: 1 cycle. Mandatory 1 idle cycle between consecutive grants (IDLE re-arbitrates on the following edge).
- Maximum grant length: exactly MAX_HOLD cycles of `grant_valid`=1; `timeout` high for 1 cycle coincident with the first `grant_valid`=0 cycle.
- Simultaneous release and timeout on the same cycle: treated as release, no `timeout` pulse.
- `req` is assumed synchronous to `clk`; synchronisers live upstream.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin. Pointer P (3 bits) starts at 0; winner is the first set `req` bit scanning ascending from P, wrapping 7→0. On every grant issue, P ← (W+1) mod 8.
- Not defined: fixed priority, highest set index wins (matches the encoder's priority order); no pointer register. A timed-out requester still holding `req` may win again after the idle cycle.

## Test plan
- Reset then `enable`=1, `req`=8'b0010_0100, hold → after 1 cycle `grant`=8'b0000_0100 (RR) or 8'b0010_0000 (fixed); HEX0=0100100 (RR) / 0010010 (fixed).
- Grantee 5 drops `req[5]` at cycle 4 of grant → next edge `grant_valid`=0, HEX0=1111111, `timeout`=0; following edge new grant if requests pending.
- MAX_HOLD=16, single `req[3]` held continuously → `grant_valid` high exactly 16 cycles, `timeout` 1-cycle pulse, 1 idle cycle, regrant of 3.
- RR mode, `req`=8'hFF held, releases by dropping each grantee's bit for one cycle → grant order 0,1,2,…,7,0.
- `enable` dropped during grant of index 7 → revoke next edge, no `timeout`; `enable`=0 with `req`≠0 keeps outputs inactive.
- Async `rst` pulse mid-grant (between edges) → `grant`=0, HEX0=1111111 immediately; after release first grant uses pointer 0.
